// File: rtl/uart_rx.sv
// uart_rx
// -------
// 8N1-style UART receiver driven by an OVERSAMPLE-times baud strobe.
// The serial line is double-flopped, the start bit is re-checked at its
// middle, data bits are sampled LSB first once per bit period, and the
// stop bit decides between delivering the byte and flagging a framing
// error. After a framing error the receiver waits for the line to return
// high so that a held-low line (break) reports only one error.
//
// Output semantics: rx_valid is a one-cycle pulse with no ready/back-
// pressure. rx_data is updated on the same edge and then held until the
// next good frame, so a consumer must take it before another frame ends.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   baud_tick    in   one-cycle strobe at OVERSAMPLE x baud
//   rx_serial    in   asynchronous serial line, idle high
//   rx_data      out  last correctly received byte
//   rx_valid     out  one-cycle pulse when rx_data is updated
//   rx_frame_err out  one-cycle pulse when the stop bit is sampled low
//   rx_busy      out  high whenever the receiver is not idle

module uart_rx #(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int CNT_W  = $clog2(OVERSAMPLE);
    localparam int BIDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0]  CNT_HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIDX_W-1:0] BIDX_LAST     = BIDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_e;

    // Synchroniser: both flops reset high so reset never looks like a start bit.
    logic sync1_q;
    logic rx_s_q;

    state_e                state_q,        state_d;
    logic [CNT_W-1:0]      cnt_q,          cnt_d;
    logic [BIDX_W-1:0]     bitidx_q,       bitidx_d;
    logic [DATA_BITS-1:0]  shift_q,        shift_d;
    logic [DATA_BITS-1:0]  rx_data_q,      rx_data_d;
    logic                  rx_valid_q,     rx_valid_d;
    logic                  rx_frame_err_q, rx_frame_err_d;
    logic                  rx_busy_q,      rx_busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx_serial;
            rx_s_q  <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            bitidx_q       <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
            rx_busy_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bitidx_q       <= bitidx_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_frame_err_q <= rx_frame_err_d;
            rx_busy_q      <= rx_busy_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bitidx_d       = bitidx_q;
        shift_d        = shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rx_frame_err_d = 1'b0;

        if (baud_tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        cnt_d   = '0;
                        state_d = S_START;
                    end
                end

                S_START: begin
                    cnt_d = cnt_q + 1'b1;
                    // Half a bit after detection: confirm we are mid start bit.
                    if (cnt_q == CNT_HALF_LAST) begin
                        if (rx_s_q) begin
                            state_d = S_IDLE;
                        end else begin
                            cnt_d    = '0;
                            bitidx_d = '0;
                            state_d  = S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    // cnt is exactly log2(OVERSAMPLE) wide, so it wraps to 0 here.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_BIT_LAST) begin
                        shift_d  = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        bitidx_d = bitidx_q + 1'b1;
                        if (bitidx_q == BIDX_LAST) begin
                            state_d = S_STOP;
                        end
                    end
                end

                S_STOP: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_BIT_LAST) begin
                        if (rx_s_q) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            state_d    = S_IDLE;
                        end else begin
                            rx_frame_err_d = 1'b1;
                            state_d        = S_BREAK;
                        end
                    end
                end

                S_BREAK: begin
                    // Only a high line rearms detection; a break gives one error.
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        rx_busy_d = (state_d != S_IDLE);
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_frame_err_q;
    assign rx_busy      = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: drives serial frames with a tick generator that
// either strobes every 4 clocks or is tied high, keeps a queue of expected
// bytes, and compares every rx_valid pulse against it.

module tb_uart_rx;

    localparam int OS = 8;
    localparam int DW = 8;
    localparam int TICK_DIV = 4;
    localparam int FRAME_TICKS = OS / 2 + (DW + 1) * OS;

    logic          clk;
    logic          rst_n;
    logic          baud_tick;
    logic          rx_serial;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_frame_err;
    logic          rx_busy;

    uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .baud_tick    (baud_tick),
        .rx_serial    (rx_serial),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    // ---------------- clock / reset / tick ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit fast_mode = 1'b0;
    int tick_cnt  = 0;
    int bit_clks  = OS * TICK_DIV;

    initial baud_tick = 1'b0;
    always @(negedge clk) begin
        if (fast_mode) begin
            baud_tick = 1'b1;
        end else begin
            tick_cnt  = (tick_cnt + 1) % TICK_DIV;
            baud_tick = (tick_cnt == 0);
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [DW-1:0] exp_q[$];
    int valid_cnt    = 0;
    int err_cnt      = 0;
    int busy_rise    = 0;
    int last_lat     = 0;
    bit busy_seen    = 1'b0;
    bit prev_valid   = 1'b0;
    bit prev_err     = 1'b0;
    bit prev_busy    = 1'b0;

    always @(negedge clk) begin
        if (rx_busy && !prev_busy) begin
            busy_rise = cyc;
            busy_seen = 1'b1;
        end
        if (rx_valid) begin
            if (prev_valid) check_eq("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
            valid_cnt++;
            last_lat = cyc - busy_rise;
            check_eq("exp_pending", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) check_eq("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
        if (rx_frame_err) begin
            if (prev_err) check_eq("err_one_cycle", {31'd0, prev_err}, 32'd0);
            err_cnt++;
        end
        prev_valid = rx_valid;
        prev_err   = rx_frame_err;
        prev_busy  = rx_busy;
    end

    // ---------------- driver tasks ----------------
    task automatic idle_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] data, input logic stop_bit);
        rx_serial = 1'b0;
        idle_clks(bit_clks);
        for (int i = 0; i < DW; i++) begin
            rx_serial = data[i];
            idle_clks(bit_clks);
        end
        rx_serial = stop_bit;
        idle_clks(bit_clks);
    endtask

    task automatic send_good(input logic [DW-1:0] data);
        exp_q.push_back(data);
        send_frame(data, 1'b1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        check_eq(tag, exp_q.size(), 32'd0);
    endtask

    task automatic wait_not_busy(input string tag, input int budget);
        int n = 0;
        while (rx_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {31'd0, rx_busy}, 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    int v0, e0;

    initial begin
        rx_serial = 1'b1;
        rst_n     = 1'b0;
        idle_clks(5);
        check_eq("reset_rx_data",  {24'd0, rx_data}, 32'd0);
        check_eq("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("reset_frame_err", {31'd0, rx_frame_err}, 32'd0);
        check_eq("reset_rx_busy",  {31'd0, rx_busy}, 32'd0);
        rst_n = 1'b1;
        idle_clks(20);

        // Good frame, with detection-to-valid latency in clocks.
        send_good(8'h41);
        idle_clks(bit_clks);
        wait_drain("drain_41");
        check_eq("valid_cnt_41", valid_cnt, 32'd1);
        check_eq("err_cnt_41", err_cnt, 32'd0);
        check_eq("busy_after_41", {31'd0, rx_busy}, 32'd0);
        check_eq("rx_data_held_41", {24'd0, rx_data}, 32'h41);
        check_eq("latency_div4", last_lat, FRAME_TICKS * TICK_DIV);
        idle_clks(2 * bit_clks);

        // Back-to-back frames with a single stop bit.
        send_good(8'h00);
        send_good(8'hFF);
        send_good(8'hA5);
        idle_clks(bit_clks);
        wait_drain("drain_b2b");
        check_eq("valid_cnt_b2b", valid_cnt, 32'd4);
        check_eq("rx_data_a5", {24'd0, rx_data}, 32'hA5);
        idle_clks(2 * bit_clks);

        // False start: two ticks of low line.
        v0 = valid_cnt;
        e0 = err_cnt;
        busy_seen = 1'b0;
        rx_serial = 1'b0;
        idle_clks(2 * TICK_DIV);
        rx_serial = 1'b1;
        idle_clks(3);
        check_eq("false_start_seen", {31'd0, busy_seen}, 32'd1);
        wait_not_busy("false_start_idle", (OS / 2) * TICK_DIV + 1);
        idle_clks(2 * bit_clks);
        check_eq("false_start_no_valid", valid_cnt - v0, 32'd0);
        check_eq("false_start_no_err", err_cnt - e0, 32'd0);
        send_good(8'h3C);
        idle_clks(bit_clks);
        wait_drain("drain_3c");
        idle_clks(2 * bit_clks);

        // Framing error followed by a break, then recovery.
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h55, 1'b0);
        idle_clks(30 * TICK_DIV);
        check_eq("frame_err_once", err_cnt - e0, 32'd1);
        check_eq("frame_err_no_valid", valid_cnt - v0, 32'd0);
        check_eq("frame_err_data_kept", {24'd0, rx_data}, 32'h3C);
        check_eq("break_busy", {31'd0, rx_busy}, 32'd1);
        rx_serial = 1'b1;
        idle_clks(2 * bit_clks);
        check_eq("break_recovered", {31'd0, rx_busy}, 32'd0);
        check_eq("break_single_err", err_cnt - e0, 32'd1);
        send_good(8'h12);
        idle_clks(bit_clks);
        wait_drain("drain_12");
        idle_clks(2 * bit_clks);

        // Reset in the middle of the data bits; release while the line is high.
        v0 = valid_cnt;
        e0 = err_cnt;
        fork
            send_frame(8'hC3, 1'b1);
            begin
                idle_clks(bit_clks * 4 + bit_clks / 2);
                rst_n = 1'b0;
                #1;
                check_eq("midreset_rx_data", {24'd0, rx_data}, 32'd0);
                check_eq("midreset_busy", {31'd0, rx_busy}, 32'd0);
                check_eq("midreset_valid", {31'd0, rx_valid}, 32'd0);
                check_eq("midreset_err", {31'd0, rx_frame_err}, 32'd0);
                idle_clks(bit_clks * 3);
                rst_n = 1'b1;
            end
        join
        rx_serial = 1'b1;
        idle_clks(3 * bit_clks);
        check_eq("midreset_no_valid", valid_cnt - v0, 32'd0);
        check_eq("midreset_no_err", err_cnt - e0, 32'd0);
        check_eq("midreset_idle", {31'd0, rx_busy}, 32'd0);
        send_good(8'h7E);
        idle_clks(bit_clks);
        wait_drain("drain_7e");
        idle_clks(2 * bit_clks);

        // Fast-tick mode: baud_tick tied high, 8 clocks per bit.
        fast_mode = 1'b1;
        bit_clks  = OS;
        idle_clks(4 * bit_clks);
        v0 = valid_cnt;
        send_good(8'h81);
        idle_clks(2 * bit_clks);
        wait_drain("drain_81");
        check_eq("fast_valid_cnt", valid_cnt - v0, 32'd1);
        check_eq("fast_rx_data", {24'd0, rx_data}, 32'h81);
        check_eq("latency_fast", last_lat, FRAME_TICKS);
        check_eq("fast_no_err", err_cnt - e0, 32'd0);

        idle_clks(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: recovers 8N1 frames from the asynchronous serial input using the 8x-oversampled strobe from the RX `baud_generator`. It is the receive counterpart of `uart_tx` in the top-level UART path. It synchronises the line, validates the start bit at mid-bit, and samples data bits LSB first. Each good byte is presented with a one-cycle valid pulse; a bad stop bit produces a one-cycle framing-error pulse.

## Interface

Parameters:
- `OVERSAMPLE`, default 8: baud_tick strobes per bit period; must be an even power of two, at least 4.
- `DATA_BITS`, default 8: data bits per frame; parity is not supported.

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset. There is one clock domain.
- `baud_tick` input 1: one-`clk`-cycle strobe at OVERSAMPLE × baud.
- `rx_serial` input 1: asynchronous serial line; idle high.
- `rx_data` output DATA_BITS: last correctly received byte; holds until the next good frame.
- `rx_valid` output 1: one-cycle pulse when `rx_data` is updated.
- `rx_frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `rx_busy` output 1: high in every state except IDLE.

## Operation

- **Synchroniser:** `rx_serial` passes through a 2-flop synchroniser whose flops reset to 1, giving `rx_s`. All decisions use `rx_s`.
- **Sampling rule:** state advances and sampling happen only on `clk` edges where `baud_tick`=1. The tick counter `cnt` has log2(OVERSAMPLE) bits.
- **IDLE:**
  - On a tick with `rx_s`=0: set `cnt`=0 and go to START.
  - Otherwise stay in IDLE.
- **START:**
  - Each tick increments `cnt`.
  - On the tick where `cnt` reaches OVERSAMPLE/2−1 (the OVERSAMPLE/2-th tick after detection, i.e. mid start bit), sample `rx_s`.
  - `rx_s`=1: false start; go to IDLE with no pulse.
  - `rx_s`=0: set `cnt`=0 and `bitidx`=0, then go to DATA.
- **DATA:**
  - Each tick increments `cnt`.
  - On the tick where `cnt` = OVERSAMPLE−1 (wrapping to 0), shift `rx_s` into the MSB of the shift register (right shift, so LSB-first on the line ends up correctly ordered) and increment `bitidx`.
  - After DATA_BITS samples, go to STOP.
- **STOP:**
  - Sample `rx_s` on the OVERSAMPLE-th tick, as in DATA.
  - Sample 1: load `rx_data` from the shift register, pulse `rx_valid`, go to IDLE.
  - Sample 0: pulse `rx_frame_err`, leave `rx_data` unchanged, go to BREAK.
- **BREAK:** wait until a tick with `rx_s`=1, then go to IDLE. A held-low line (break) therefore produces exactly one error and never re-triggers.
- **No buffering:** `rx_valid` has no ready handshake, and the consumer must capture `rx_data` before the next frame completes. Overrun is not flagged.
- **`baud_tick` outside a frame:** has no effect apart from IDLE start detection.

## Timing

- **Reset values:** state=IDLE, `rx_data`=0, `rx_valid`=0, `rx_frame_err`=0, `rx_busy`=0, `cnt`=0, synchroniser flops=1.
- **Synchroniser latency:** a line edge is visible in `rx_s` 2 `clk` edges later.
- **Output registers:** all outputs are registered.
  - `rx_valid` or `rx_frame_err` goes high on the `clk` edge that processes the stop-bit sample tick and stays high for exactly one cycle.
  - `rx_data` changes on that same edge.
- **Frame length:** detection to `rx_valid` is OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE ticks, which is 76 ticks at defaults.
- **Earliest next detection:** the next start bit can be detected on the first tick after returning to IDLE, so back-to-back frames with one stop bit are received.
- **Reset mid-frame:** asynchronous return to IDLE. The partial byte is discarded and no pulse is issued.
- **Tick spacing:** consecutive-cycle `baud_tick` is legal, and the block must work with `baud_tick` tied high for simulation.

## Test plan

- **Good frame:** send 0x41 (8N1, 8 ticks/bit, `baud_tick` every 4 clk) → exactly one `rx_valid` pulse with `rx_data`=0x41, `rx_frame_err`=0, `rx_busy` low afterwards.
- **Back-to-back frames:** send 0x00, 0xFF, 0xA5 with one stop bit each → three `rx_valid` pulses with `rx_data` 0x00, 0xFF, 0xA5 in order.
- **False start:** low glitch lasting 2 ticks on an idle line → no pulse, `rx_busy` returns to 0 within OVERSAMPLE/2 ticks. A following 0x3C is then received correctly.
- **Framing error and break recovery:** send 0x55 with stop=0, then hold the line low for 30 ticks, then high, then send 0x12.
  - One `rx_frame_err` pulse; `rx_data` keeps its previous value.
  - No further pulses while the line is low.
  - 0x12 is then received with `rx_valid`.
- **Reset mid-frame:** assert `rst_n`=0 mid-data of 0xC3 → all outputs return to reset values immediately. After release, the remaining bits produce no `rx_valid`, and a fresh 0x7E is received correctly.
- **Fast-tick mode:** `baud_tick` tied high, send 0x81 at 8 clk/bit → `rx_data`=0x81 with `rx_valid` 76 cycles after start-bit detection.
